// File: rtl/bp_pkg.sv
// Shared types for the gshare + RAS branch predictor.
//   btype_e   : control-flow class reported by EX (encodings 4..7 act as NONE)
//   etype_e   : control-flow class remembered in a BTB entry
//   CNT_*     : 2-bit saturating direction counter encodings
//   sat_update: one step of the saturating counter toward the resolved direction
package bp_pkg;

  typedef enum logic [2:0] {
    BT_NONE = 3'd0,
    BT_JAL  = 3'd1,
    BT_BR   = 3'd2,
    BT_JALR = 3'd3
  } btype_e;

  typedef enum logic [1:0] {
    ET_BR   = 2'd0,
    ET_JAL  = 2'd1,
    ET_JALR = 2'd2,
    ET_RET  = 2'd3
  } etype_e;

  localparam logic [1:0] CNT_SN = 2'b00;
  localparam logic [1:0] CNT_WN = 2'b01;
  localparam logic [1:0] CNT_WT = 2'b10;
  localparam logic [1:0] CNT_ST = 2'b11;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    else       return (cnt == CNT_SN) ? CNT_SN : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack.
//   clk, rst    : clock, synchronous active-high reset (stack becomes empty)
//   push_i      : push push_data_i (already qualified by the caller)
//   pop_i       : pop the top entry; ignored when empty
//   push_data_i : return address to push
//   top_o       : current top entry (meaningless when empty_o)
//   empty_o     : no valid entries
// A push onto a full stack wraps and overwrites the oldest entry; the count
// saturates at DEPTH so exactly DEPTH returns can still be served.
module bp_ras #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;     // index of the top entry
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_pop, wr_en;
  logic [PW-1:0]    wr_ptr;

  always_comb begin
    do_pop = pop_i & (cnt_q != '0);
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = ptr_q;
    if (do_pop && push_i) begin
      // pop then push collapses to replacing the top in place
      wr_en = 1'b1;
    end else if (push_i) begin
      ptr_d  = ptr_q + 1'b1;
      wr_ptr = ptr_q + 1'b1;
      wr_en  = 1'b1;
      cnt_d  = (cnt_q == FULL) ? cnt_q : cnt_q + 1'b1;
    end else if (do_pop) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) stack_q[wr_ptr] <= push_data_i;
  end

  assign top_o   = stack_q[ptr_q];
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/gshare_ras_predictor.sv
// IF-stage branch predictor: direct-mapped BTB, gshare PHT, return-address stack.
//   clk, rst               : clock, synchronous active-high reset
//   IF_DONE, MEM_DONE      : both high enables training on this edge
//   IF_PC                  : fetch PC; IF_pTaken/IF_pTarget is the combinational prediction
//   EX_bType..EX_pTarget   : resolved control-flow instruction plus its carried prediction
//   EX_mispredict          : resolution disagrees with the carried prediction
//   br_cnt, mispred_cnt    : wrapping performance counters
// Lookups read pre-edge state; a same-cycle update to the same index is not forwarded.
module gshare_ras_predictor
  import bp_pkg::*;
#(
  parameter int PC_WIDTH    = 16,
  parameter int BTB_ENTRIES = 16,
  parameter int PHT_ENTRIES = 64,
  parameter int GHR_WIDTH   = 6,
  parameter int RAS_DEPTH   = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                IF_DONE,
  input  logic                MEM_DONE,
  input  logic [PC_WIDTH-1:0] IF_PC,
  output logic                IF_pTaken,
  output logic [PC_WIDTH-1:0] IF_pTarget,
  input  logic [2:0]          EX_bType,
  input  logic                EX_isCall,
  input  logic                EX_isRet,
  input  logic                EX_rTaken,
  input  logic [PC_WIDTH-1:0] EX_PC,
  input  logic [PC_WIDTH-1:0] EX_bTarget,
  input  logic                EX_pTaken,
  input  logic [PC_WIDTH-1:0] EX_pTarget,
  output logic                EX_mispredict,
  output logic [CNT_WIDTH-1:0] br_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);
  localparam int BTB_IW = $clog2(BTB_ENTRIES);
  localparam int PHT_IW = $clog2(PHT_ENTRIES);
  localparam int TAG_W  = PC_WIDTH - BTB_IW - 2;

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [PC_WIDTH-1:0] target;
    etype_e              etype;
  } btb_entry_t;

  btb_entry_t           btb_q [BTB_ENTRIES];
  logic [1:0]           pht_q [PHT_ENTRIES];
  logic [GHR_WIDTH-1:0] ghr_q;
  logic [CNT_WIDTH-1:0] br_cnt_q, mis_cnt_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{IF_PC[1:0], EX_PC[1:0]};

  // ---------------- IF lookup ----------------
  logic [BTB_IW-1:0]   if_idx;
  logic [PHT_IW-1:0]   if_pht_idx;
  btb_entry_t          if_ent;
  logic                if_hit;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_empty;

  assign if_idx     = IF_PC[BTB_IW+1:2];
  assign if_pht_idx = IF_PC[PHT_IW+1:2] ^ PHT_IW'(ghr_q);
  assign if_ent     = btb_q[if_idx];
  assign if_hit     = if_ent.valid && (if_ent.tag == IF_PC[PC_WIDTH-1:BTB_IW+2]);

  always_comb begin
    IF_pTaken  = 1'b0;
    IF_pTarget = '0;
    if (if_hit) begin
      IF_pTarget = if_ent.target;
      case (if_ent.etype)
        ET_BR:   IF_pTaken = pht_q[if_pht_idx][1];
        ET_RET: begin
          IF_pTaken = 1'b1;
          if (!ras_empty) IF_pTarget = ras_top;
        end
        default: IF_pTaken = 1'b1;
      endcase
    end
  end

  // ---------------- EX resolution ----------------
  logic                upd_en, ex_is_br, ex_is_jmp, ex_valid, ex_hit;
  logic [BTB_IW-1:0]   ex_idx;
  logic [TAG_W-1:0]    ex_tag;
  logic [PHT_IW-1:0]   ex_pht_idx;
  btb_entry_t          ex_ent, btb_wdata;
  logic                btb_we, pht_we;
  logic [1:0]          pht_wdata;

  assign upd_en     = IF_DONE & MEM_DONE;
  assign ex_is_br   = (EX_bType == BT_BR);
  assign ex_is_jmp  = (EX_bType == BT_JAL) || (EX_bType == BT_JALR);
  assign ex_valid   = ex_is_br | ex_is_jmp;
  assign ex_idx     = EX_PC[BTB_IW+1:2];
  assign ex_tag     = EX_PC[PC_WIDTH-1:BTB_IW+2];
  assign ex_pht_idx = EX_PC[PHT_IW+1:2] ^ PHT_IW'(ghr_q);   // pre-shift history
  assign ex_ent     = btb_q[ex_idx];
  assign ex_hit     = ex_ent.valid && (ex_ent.tag == ex_tag);

  assign EX_mispredict = ex_valid &
      ((EX_pTaken != EX_rTaken) | (EX_rTaken & (EX_pTarget != EX_bTarget)));

  always_comb begin
    btb_wdata.valid  = 1'b1;
    btb_wdata.tag    = ex_tag;
    btb_wdata.target = EX_bTarget;
    btb_wdata.etype  = ET_BR;
    btb_we           = 1'b0;
    pht_we           = upd_en & ex_is_br;
    // a freshly allocated branch starts weakly taken rather than trained from an alias
    pht_wdata        = (!ex_hit && EX_rTaken) ? CNT_WT : sat_update(pht_q[ex_pht_idx], EX_rTaken);
    if (ex_is_br) begin
      btb_we          = upd_en & EX_rTaken;
      btb_wdata.etype = ex_hit ? ex_ent.etype : ET_BR;
    end else if (ex_is_jmp) begin
      btb_we          = upd_en;
      btb_wdata.etype = EX_isRet ? ET_RET : ((EX_bType == BT_JAL) ? ET_JAL : ET_JALR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_q[i].valid <= 1'b0;
    end else if (btb_we) begin
      btb_q[ex_idx] <= btb_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= CNT_WT;
    end else if (pht_we) begin
      pht_q[ex_pht_idx] <= pht_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q     <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (upd_en) begin
      // the cast keeps the low bits, which also covers a 1-bit history
      if (ex_is_br) ghr_q <= GHR_WIDTH'({ghr_q, EX_rTaken});
      br_cnt_q  <= br_cnt_q + CNT_WIDTH'(ex_valid);
      mis_cnt_q <= mis_cnt_q + CNT_WIDTH'(EX_mispredict);
    end
  end

  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mis_cnt_q;

  bp_ras #(
    .DEPTH(RAS_DEPTH),
    .WIDTH(PC_WIDTH)
  ) u_ras (
    .clk        (clk),
    .rst        (rst),
    .push_i     (upd_en & ex_is_jmp & EX_isCall),
    .pop_i      (upd_en & ex_is_jmp & EX_isRet),
    .push_data_i(EX_PC + PC_WIDTH'(4)),
    .top_o      (ras_top),
    .empty_o    (ras_empty)
  );

endmodule
